// File: rtl/stft_threshold_comparator.sv
// Binarises NCH STFT magnitude lanes per beat against a runtime-loaded per-bin threshold table (optional hit counter: COMP_HITCNT_EN).
// Latency: 2 cycles iEN -> oEN, one beat per cycle sustained.
// Backpressure: none; iCLR flushes in-flight beats, the threshold table survives iCLR and iRST.
module stft_threshold_comparator #(
    parameter int IL   = 10,
    parameter int NCH  = 4,
    parameter int NBIN = 512,
    parameter int AW   = 7,
    parameter int HCW  = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCLR,
    input  logic              iEN,
    input  logic [NCH*IL-1:0] iDATA,
    input  logic [1:0]        iMODE,
    input  logic [IL-1:0]     iHYST,
    input  logic              iTH_WE,
    input  logic [AW-1:0]     iTH_ADDR,
    input  logic [NCH*IL-1:0] iTH_DATA,
    output logic              oEN,
    output logic [NCH-1:0]    oDATA,
    output logic              oLAST,
    output logic [AW-1:0]     oCNT,
    output logic [HCW-1:0]    oHITCNT,
    output logic              oHIT_VALID
);

    localparam int            NBEAT     = NBIN / NCH;
    localparam logic [AW-1:0] LASTBEAT  = AW'(NBEAT - 1);
    localparam logic [1:0]    MODE_GT   = 2'd1;
    localparam logic [1:0]    MODE_HYST = 2'd2;

    logic [NCH*IL-1:0] thTable [0:(2**AW)-1];

    logic              accept;
    logic [AW-1:0]     beatCnt;
    logic              s0Vld;
    logic [NCH*IL-1:0] s0Data;
    logic [NCH*IL-1:0] s0Th;
    logic [1:0]        s0Mode;
    logic [IL-1:0]     s0Hyst;
    logic [AW-1:0]     s0Cnt;
    logic [NCH-1:0]    hystState;
    logic [NCH-1:0]    flagNext;
    logic [NCH-1:0]    hystNext;

    assign accept = iEN && !iCLR;

    // Read-first: the registered read sees the pre-write contents on an address collision.
    always_ff @(posedge iCLK) begin
        if (iTH_WE) begin
            thTable[iTH_ADDR] <= iTH_DATA;
        end
        if (accept) begin
            s0Th <= thTable[beatCnt];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            beatCnt <= '0;
            s0Vld   <= 1'b0;
            s0Data  <= '0;
            s0Mode  <= '0;
            s0Hyst  <= '0;
            s0Cnt   <= '0;
        end else if (iCLR) begin
            beatCnt <= '0;
            s0Vld   <= 1'b0;
        end else begin
            s0Vld <= iEN;
            if (iEN) begin
                s0Data  <= iDATA;
                s0Mode  <= iMODE;
                s0Hyst  <= iHYST;
                s0Cnt   <= beatCnt;
                beatCnt <= (beatCnt == LASTBEAT) ? '0 : beatCnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : gLane
        logic [IL-1:0] laneD;
        logic [IL-1:0] laneT;
        logic [IL-1:0] laneLo;
        logic          prevS;
        logic          hystFlag;

        assign laneD    = s0Data[k*IL +: IL];
        assign laneT    = s0Th[k*IL +: IL];
        assign laneLo   = (laneT > s0Hyst) ? laneT - s0Hyst : '0;
        // Beat 0 of a frame always starts the hysteresis from a cleared state.
        assign prevS    = (s0Cnt != '0) && hystState[k];
        assign hystFlag = (laneD >= laneT) ? 1'b1 : ((laneD < laneLo) ? 1'b0 : prevS);

        assign flagNext[k] = (s0Mode == MODE_GT)   ? (laneD > laneT) :
                             (s0Mode == MODE_HYST) ? hystFlag : (laneD >= laneT);
        assign hystNext[k] = (s0Mode == MODE_HYST) && hystFlag;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oEN       <= 1'b0;
            oDATA     <= '0;
            oLAST     <= 1'b0;
            oCNT      <= '0;
            hystState <= '0;
        end else if (iCLR) begin
            oEN       <= 1'b0;
            oLAST     <= 1'b0;
            hystState <= '0;
        end else begin
            oEN   <= s0Vld;
            oLAST <= s0Vld && (s0Cnt == LASTBEAT);
            if (s0Vld) begin
                oDATA     <= flagNext;
                oCNT      <= s0Cnt;
                // Any non-hysteresis beat breaks the chain of mode-2 state.
                hystState <= hystNext;
            end
        end
    end

`ifdef COMP_HITCNT_EN
    logic [HCW-1:0] hitAcc;
    logic [HCW-1:0] hitSum;

    function automatic logic [HCW-1:0] popCount(input logic [NCH-1:0] v);
        logic [HCW-1:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + HCW'(v[i]);
        end
        return n;
    endfunction

    assign hitSum = hitAcc + popCount(flagNext);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hitAcc     <= '0;
            oHITCNT    <= '0;
            oHIT_VALID <= 1'b0;
        end else if (iCLR) begin
            hitAcc     <= '0;
            oHIT_VALID <= 1'b0;
        end else begin
            oHIT_VALID <= 1'b0;
            if (s0Vld) begin
                if (s0Cnt == LASTBEAT) begin
                    oHITCNT    <= hitSum;
                    oHIT_VALID <= 1'b1;
                    hitAcc     <= '0;
                end else begin
                    hitAcc <= hitSum;
                end
            end
        end
    end
`else
    assign oHITCNT    = '0;
    assign oHIT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_stft_threshold_comparator.sv
// Bench for stft_threshold_comparator: directed spectrogram scenarios plus random beats,
// checked against a per-bin arithmetic reference of the comparator rules.
module tb_stft_threshold_comparator;

`ifdef COMP_HITCNT_EN
    localparam bit HITEN = 1'b1;
`else
    localparam bit HITEN = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iCLR = 1'b0;
    logic        iEN = 1'b0;
    logic [39:0] iDATA = '0;
    logic [1:0]  iMODE = '0;
    logic [9:0]  iHYST = '0;
    logic        iTH_WE = 1'b0;
    logic [6:0]  iTH_ADDR = '0;
    logic [39:0] iTH_DATA = '0;
    logic        oEN;
    logic [3:0]  oDATA;
    logic        oLAST;
    logic [6:0]  oCNT;
    logic [9:0]  oHITCNT;
    logic        oHIT_VALID;

    stft_threshold_comparator dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iEN(iEN), .iDATA(iDATA),
        .iMODE(iMODE), .iHYST(iHYST), .iTH_WE(iTH_WE), .iTH_ADDR(iTH_ADDR),
        .iTH_DATA(iTH_DATA), .oEN(oEN), .oDATA(oDATA), .oLAST(oLAST),
        .oCNT(oCNT), .oHITCNT(oHITCNT), .oHIT_VALID(oHIT_VALID)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        bit       vld;
        bit [3:0] flags;
        bit       last;
        int       cnt;
        int       hit;
        bit       hv;
    } rec_t;

    int   nAssert = 0;
    int   nFail = 0;
    int   thr [128][4];
    int   hs [4];
    int   mCnt = 0, mAcc = 0, mHit = 0, mPrevMode = 0;
    rec_t st1, st2;
    bit        tWe = 0;
    bit [6:0]  tAddr = 0;
    bit [39:0] tDat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pack(input int a, input int b, input int c, input int d);
        logic [9:0] la, lb, lc, ld;
        la = a[9:0]; lb = b[9:0]; lc = c[9:0]; ld = d[9:0];
        return {ld, lc, lb, la};
    endfunction

    // One clock: check what the beat from two clocks ago produced, drive the new beat, advance the model.
    task automatic step(input bit en, input logic [39:0] data, input logic [1:0] mode,
                        input logic [9:0] hyst, input bit clr, input bit rst);
        rec_t r;
        int t, d, lo, pop;
        bit prev;
        bit [3:0] f;
        @(negedge iCLK);
        chk("oEN", {31'd0, oEN}, {31'd0, st2.vld});
        chk("oLAST", {31'd0, oLAST}, {31'd0, st2.last});
        chk("oHITCNT", {22'd0, oHITCNT}, HITEN ? st2.hit : 0);
        chk("oHIT_VALID", {31'd0, oHIT_VALID}, HITEN ? {31'd0, st2.hv} : 0);
        if (st2.vld) begin
            chk("oDATA", {28'd0, oDATA}, {28'd0, st2.flags});
            chk("oCNT", {25'd0, oCNT}, st2.cnt);
        end
        iEN = en; iDATA = data; iMODE = mode; iHYST = hyst; iCLR = clr; iRST = rst;
        iTH_WE = tWe; iTH_ADDR = tAddr; iTH_DATA = tDat;
        r.vld = 0; r.flags = 0; r.last = 0; r.cnt = 0; r.hv = 0;
        if (rst) begin
            mCnt = 0; mAcc = 0; mHit = 0; mPrevMode = 0;
        end else if (clr) begin
            mCnt = 0; mAcc = 0; mHit = st2.hit; mPrevMode = 0;
        end else if (en) begin
            pop = 0;
            for (int k = 0; k < 4; k++) begin
                t = thr[mCnt][k];
                d = int'(data[k*10 +: 10]);
                if (mode == 2'd1) begin
                    f[k] = d > t;
                end else if (mode == 2'd2) begin
                    lo = t - int'(hyst);
                    if (lo < 0) lo = 0;
                    prev = (mCnt != 0 && mPrevMode == 2) ? hs[k][0] : 1'b0;
                    f[k] = (d >= t) ? 1'b1 : ((d < lo) ? 1'b0 : prev);
                    hs[k] = int'(f[k]);
                end else begin
                    f[k] = d >= t;
                end
                pop += int'(f[k]);
            end
            mPrevMode = int'(mode);
            r.vld = 1; r.flags = f; r.cnt = mCnt; r.last = (mCnt == 127);
            mAcc += pop;
            if (r.last) begin
                mHit = mAcc; mAcc = 0; r.hv = 1;
            end
            mCnt = (mCnt + 1) % 128;
        end
        r.hit = mHit;
        if (tWe) begin
            for (int k = 0; k < 4; k++) thr[tAddr][k] = int'(tDat[k*10 +: 10]);
        end
        @(posedge iCLK);
        if (rst || clr) begin
            st1 = r; st2 = r;
        end else begin
            st2 = st1; st1 = r;
        end
        tWe = 0;
    endtask

    task automatic idle();
        step(0, '0, 2'd0, '0, 0, 0);
    endtask

    initial begin
        logic [39:0] dat;
        logic [1:0]  md;
        logic [9:0]  hy;
        bit          hexp [7];
        int          hseq [7];
        int          v [4];
        st1.vld = 0; st1.flags = 0; st1.last = 0; st1.cnt = 0; st1.hit = 0; st1.hv = 0;
        st2 = st1;
        for (int a = 0; a < 128; a++) for (int k = 0; k < 4; k++) thr[a][k] = 0;
        for (int k = 0; k < 4; k++) hs[k] = 0;

        // Reset state
        step(0, '0, 2'd0, '0, 0, 1);
        step(0, '0, 2'd0, '0, 0, 1);
        #1;
        chk("rst_oEN", {31'd0, oEN}, 0);
        chk("rst_oDATA", {28'd0, oDATA}, 0);
        chk("rst_oLAST", {31'd0, oLAST}, 0);
        chk("rst_oCNT", {25'd0, oCNT}, 0);
        chk("rst_oHITCNT", {22'd0, oHITCNT}, 0);
        chk("rst_oHIT_VALID", {31'd0, oHIT_VALID}, 0);

        // All thresholds 100
        for (int a = 0; a < 128; a++) begin
            tWe = 1; tAddr = a[6:0]; tDat = pack(100, 100, 100, 100);
            idle();
        end

        // Mode 0 / 1 / 3 on the same beat
        dat = pack(99, 100, 101, 1023);
        step(1, dat, 2'd0, '0, 0, 0); idle(); #1 chk("mode0_flags", {28'd0, oDATA}, 32'b1110);
        step(1, dat, 2'd1, '0, 0, 0); idle(); #1 chk("mode1_flags", {28'd0, oDATA}, 32'b1100);
        step(1, dat, 2'd3, '0, 0, 0); idle(); #1 chk("mode3_flags", {28'd0, oDATA}, 32'b1110);

        // Hysteresis on lane 0, starting at beat 0 of a fresh frame
        hseq = '{0, 105, 90, 79, 85, 105, 0};
        hexp = '{0, 1, 1, 0, 0, 1, 1};
        step(0, '0, 2'd0, '0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, pack(hseq[i], 0, 0, 0), 2'd2, (i < 5) ? 10'd20 : 10'd200, 0, 0);
            idle();
            #1 chk("hyst_lane0", {31'd0, oDATA[0]}, {31'd0, hexp[i]});
        end

        // Frame wrap with hysteresis set on beat 127 and a mid-band value on the next beat 0
        step(0, '0, 2'd0, '0, 1, 0);
        for (int i = 0; i < 132; i++) begin
            for (int k = 0; k < 4; k++) v[k] = $urandom_range(0, 200);
            if (i == 127) for (int k = 0; k < 4; k++) v[k] = 150;
            if (i == 128) for (int k = 0; k < 4; k++) v[k] = 90;
            step(1, pack(v[0], v[1], v[2], v[3]), 2'd2, 10'd20, 0, 0);
        end
        idle(); idle(); idle();

        // iCLR with iEN on beat 5 of a burst
        step(0, '0, 2'd0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, pack(i * 30, 100, 150, 50), 2'd0, '0, 0, 0);
        step(1, pack(200, 200, 200, 200), 2'd0, '0, 1, 0);
        idle(); idle(); idle();
        step(1, pack(100, 99, 0, 1023), 2'd1, '0, 0, 0);
        idle(); idle();

        // Full frame against zero thresholds: every lane hits
        for (int a = 0; a < 128; a++) begin
            tWe = 1; tAddr = a[6:0]; tDat = '0;
            idle();
        end
        step(0, '0, 2'd0, '0, 1, 0);
        for (int i = 0; i < 128; i++) step(1, {$urandom, $urandom}, 2'd0, '0, 0, 0);
        idle(); idle(); idle();

        // Random thresholds, beats, modes, table writes, clears and one mid-frame reset
        for (int a = 0; a < 128; a++) begin
            tWe = 1; tAddr = a[6:0]; tDat = {$urandom, $urandom};
            idle();
        end
        md = 2'd2;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            hy = 10'($urandom_range(0, 150));
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) v[k] = $urandom_range(0, 1023);
                else v[k] = thr[mCnt][k] + $urandom_range(0, 60) - 30;
            end
            if ($urandom_range(0, 3) == 0) begin
                tWe = 1;
                tAddr = ($urandom_range(0, 1) == 0) ? mCnt[6:0] : 7'($urandom_range(0, 127));
                tDat = {$urandom, $urandom};
            end
            step($urandom_range(0, 7) != 0, pack(v[0], v[1], v[2], v[3]), md, hy,
                 $urandom_range(0, 199) == 0, i == 350);
        end
        idle(); idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
